// File: rtl/axi4_frame_fetch_if.sv
// AXI4 read-address and read-data channels used by the frame fetcher.
interface axi4_frame_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic [3:0]        ARCACHE;
    logic [2:0]        ARPROT;
    logic              RVALID;
    logic              RREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;

    modport master (
        output ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT, RREADY,
        input  ARREADY, RVALID, RDATA, RRESP, RLAST
    );

    modport slave (
        input  ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT, RREADY,
        output ARREADY, RVALID, RDATA, RRESP, RLAST
    );
endinterface

// File: rtl/axi4_frame_fetch.sv
// AXI4 read master that streams one frame per frame_start into a downstream write port,
// with credit-based flow control, several outstanding bursts and a clean abort/drain path.
module axi4_frame_fetch #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int BURST_LEN      = 64,
    parameter int MAX_OUTST      = 4,
    parameter int SPACE_W        = 11
) (
    input  logic                      clk_100Mhz,
    input  logic                      rst,
    input  logic                      i_frame_start,
    input  logic                      i_buf_select,
    input  logic [AXI_ADDR_WIDTH-1:0] i_base_addr0,
    input  logic [AXI_ADDR_WIDTH-1:0] i_base_addr1,
    input  logic [15:0]               i_frame_bursts,
    input  logic [SPACE_W-1:0]        i_out_space,
    output logic                      o_out_wr_en,
    output logic [AXI_DATA_WIDTH-1:0] o_out_data,
    output logic                      o_out_last,
    output logic                      o_frame_done,
    output logic                      o_rresp_err,
    output logic                      o_busy,
    output logic [1:0]                o_state,
    output logic [15:0]               o_burst_cnt,
    axi4_frame_fetch_if.master        axi
);
    localparam int BEAT_BYTES  = AXI_DATA_WIDTH / 8;
    localparam int BURST_SHIFT = $clog2(BURST_LEN * BEAT_BYTES);
    localparam int RES_W       = $clog2(MAX_OUTST * BURST_LEN + 1);
    localparam int OUT_W       = $clog2(MAX_OUTST + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    r_state;
    logic [15:0]               r_issued;
    logic [15:0]               r_rcv_bursts;
    logic [15:0]               r_nbursts;
    logic [15:0]               r_pend_bursts;
    logic                      r_pend_sel;
    logic [RES_W-1:0]          r_reserved;
    logic [OUT_W-1:0]          r_outst;
    logic [AXI_ADDR_WIDTH-1:0] r_base;
    logic [AXI_ADDR_WIDTH-1:0] r_araddr;
    logic                      r_arvalid;
    logic                      r_rready;
    logic                      r_out_wr_en;
    logic [AXI_DATA_WIDTH-1:0] r_out_data;
    logic                      r_out_last;
    logic                      r_frame_done;
    logic                      r_rresp_err;

    logic                      w_beat;
    logic                      w_ar_hs;
    logic                      w_final_beat;
    logic                      w_drain_clear;
    logic                      w_space_ok;
    logic                      w_issue;
    logic                      w_start;
    logic                      w_start_sel;
    logic [15:0]               w_start_bursts;
    logic [RES_W-1:0]          w_reserved_nxt;
    logic [OUT_W-1:0]          w_outst_nxt;
    logic [AXI_ADDR_WIDTH-1:0] w_next_addr;

    assign w_beat        = axi.RVALID && r_rready;
    assign w_ar_hs       = r_arvalid && axi.ARREADY;
    assign w_final_beat  = (r_state == S_RUN) && w_beat && axi.RLAST &&
                           (r_rcv_bursts == r_nbursts - 16'd1);
    assign w_drain_clear = (r_reserved == '0) && !r_arvalid;

    // Credit: never request more beats than the downstream can absorb, counting beats in flight
    assign w_space_ok = 32'(i_out_space) >= (32'(r_reserved) + 32'(BURST_LEN));
    assign w_issue    = (r_state == S_RUN) && !i_frame_start && !r_arvalid &&
                        (r_issued < r_nbursts) && (r_outst < OUT_W'(MAX_OUTST)) && w_space_ok;

    assign w_start = ((r_state == S_IDLE || r_state == S_DONE) && i_frame_start) ||
                     ((r_state == S_RUN) && i_frame_start && (w_drain_clear || w_final_beat)) ||
                     ((r_state == S_DRAIN) && w_drain_clear);
    assign w_start_sel    = i_frame_start ? i_buf_select : r_pend_sel;
    assign w_start_bursts = i_frame_start ? i_frame_bursts : r_pend_bursts;

    assign w_reserved_nxt = r_reserved + (w_ar_hs ? RES_W'(BURST_LEN) : '0) - (w_beat ? RES_W'(1) : '0);
    assign w_outst_nxt    = r_outst + OUT_W'(w_ar_hs) - OUT_W'(w_beat && axi.RLAST);
    assign w_next_addr    = r_base + (AXI_ADDR_WIDTH'(r_issued) << BURST_SHIFT);

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_issued      <= '0;
            r_rcv_bursts  <= '0;
            r_nbursts     <= '0;
            r_pend_bursts <= '0;
            r_pend_sel    <= 1'b0;
            r_reserved    <= '0;
            r_outst       <= '0;
            r_base        <= '0;
            r_araddr      <= '0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_out_wr_en   <= 1'b0;
            r_out_data    <= '0;
            r_out_last    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_rresp_err   <= 1'b0;
        end else begin
            r_rready     <= 1'b1;
            r_out_wr_en  <= w_beat && (r_state == S_RUN);
            r_out_last   <= w_final_beat;
            r_frame_done <= w_final_beat;
            r_reserved   <= w_reserved_nxt;
            r_outst      <= w_outst_nxt;
            if (w_beat && (r_state == S_RUN)) begin
                r_out_data <= axi.RDATA;
            end
            if (w_beat && axi.RLAST) begin
                r_rcv_bursts <= r_rcv_bursts + 16'd1;
            end
            if (w_beat && (axi.RRESP != 2'b00)) begin
                r_rresp_err <= 1'b1;
            end
            if (w_ar_hs) begin
                r_arvalid <= 1'b0;
                r_issued  <= r_issued + 16'd1;
            end

            case (r_state)
                S_RUN: begin
                    if (w_issue) begin
                        r_arvalid <= 1'b1;
                        r_araddr  <= w_next_addr;
                    end
                    if (w_final_beat) begin
                        r_state <= S_DONE;
                    end
                    if (i_frame_start) begin
                        r_state       <= S_DRAIN;
                        r_pend_sel    <= i_buf_select;
                        r_pend_bursts <= i_frame_bursts;
                    end
                end
                S_DRAIN: begin
                    if (i_frame_start) begin
                        r_pend_sel    <= i_buf_select;
                        r_pend_bursts <= i_frame_bursts;
                    end
                end
                default: ;
            endcase

            // A frame start overrides everything above; an empty frame completes at once
            if (w_start) begin
                r_base       <= w_start_sel ? i_base_addr1 : i_base_addr0;
                r_nbursts    <= w_start_bursts;
                r_issued     <= '0;
                r_rcv_bursts <= '0;
                r_reserved   <= '0;
                r_outst      <= '0;
                r_rresp_err  <= 1'b0;
                r_state      <= (w_start_bursts == 16'd0) ? S_DONE : S_RUN;
                r_frame_done <= (w_start_bursts == 16'd0) || w_final_beat;
            end
        end
    end

    assign axi.ARADDR  = r_araddr;
    assign axi.ARVALID = r_arvalid;
    assign axi.ARLEN   = 8'(BURST_LEN - 1);
    assign axi.ARSIZE  = 3'($clog2(BEAT_BYTES));
    assign axi.ARBURST = 2'b01;
    assign axi.ARCACHE = 4'b0011;
    assign axi.ARPROT  = 3'b000;
    assign axi.RREADY  = r_rready;

    assign o_out_wr_en  = r_out_wr_en;
    assign o_out_data   = r_out_data;
    assign o_out_last   = r_out_last;
    assign o_frame_done = r_frame_done;
    assign o_rresp_err  = r_rresp_err;
    assign o_busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_state      = r_state;
    assign o_burst_cnt  = r_issued;
endmodule

// File: tb/tb_axi4_frame_fetch.sv
// Directed bench for axi4_frame_fetch: a small AXI slave model plus a write-port monitor,
// driven by one linear sequence of frames (4-beat bursts of 32-bit words, 16 bytes each).
module tb_axi4_frame_fetch;
    logic        clk_100Mhz = 1'b0;
    logic        rst = 1'b1;
    logic        frameStart = 1'b0;
    logic        bufSelect = 1'b0;
    logic [31:0] baseAddr0 = 32'h1000_0000;
    logic [31:0] baseAddr1 = 32'h2000_0000;
    logic [15:0] frameBursts = 16'd0;
    logic [10:0] outSpace = 11'd1024;
    logic        outWrEn, outLast, frameDone, rrespErr, busy;
    logic [31:0] outData;
    logic [1:0]  state;
    logic [15:0] burstCnt;

    int nCompared = 0;
    int nMismatched = 0;

    axi4_frame_fetch_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    axi4_frame_fetch #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .BURST_LEN(4), .MAX_OUTST(4), .SPACE_W(11)
    ) dut (
        .clk_100Mhz(clk_100Mhz), .rst(rst), .i_frame_start(frameStart), .i_buf_select(bufSelect),
        .i_base_addr0(baseAddr0), .i_base_addr1(baseAddr1), .i_frame_bursts(frameBursts),
        .i_out_space(outSpace), .o_out_wr_en(outWrEn), .o_out_data(outData), .o_out_last(outLast),
        .o_frame_done(frameDone), .o_rresp_err(rrespErr), .o_busy(busy), .o_state(state),
        .o_burst_cnt(burstCnt), .axi(axi)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    // Slave model: in-order bursts, data word = burst address + 4*beat, R gated by rBurstLimit
    logic [31:0] arQ[$];
    logic [31:0] arLog[0:255];
    int arCount = 0;
    int beatCount = 0;
    int beatIdx = 0;
    int rBurstsDone = 0;
    int rBurstLimit = 1000000;
    int errBeatNum = -1;

    always @(posedge clk_100Mhz) begin
        if (rst) begin
            axi.RVALID <= 1'b0;
            axi.RLAST  <= 1'b0;
            axi.RRESP  <= 2'b00;
            axi.RDATA  <= '0;
            arQ.delete();
            beatIdx = 0;
        end else begin
            if (axi.ARVALID && axi.ARREADY) begin
                arQ.push_back(axi.ARADDR);
                arLog[arCount] = axi.ARADDR;
                arCount++;
            end
            if (axi.RVALID && axi.RREADY) begin
                beatCount++;
                if (axi.RLAST) begin
                    void'(arQ.pop_front());
                    beatIdx = 0;
                    rBurstsDone++;
                end else begin
                    beatIdx++;
                end
            end
            if (arQ.size() > 0 && rBurstsDone < rBurstLimit) begin
                axi.RVALID <= 1'b1;
                axi.RDATA  <= arQ[0] + 32'(beatIdx * 4);
                axi.RLAST  <= (beatIdx == 3);
                axi.RRESP  <= (beatCount + 1 == errBeatNum) ? 2'b10 : 2'b00;
            end else begin
                axi.RVALID <= 1'b0;
                axi.RLAST  <= 1'b0;
                axi.RRESP  <= 2'b00;
            end
        end
    end

    logic [31:0] wrLog[0:1023];
    logic [31:0] lastData = '0;
    int wrCount = 0;
    int lastCount = 0;
    int doneCount = 0;

    always @(posedge clk_100Mhz) begin
        if (outWrEn) begin
            wrLog[wrCount] = outData;
            wrCount++;
            if (outLast) begin
                lastCount++;
                lastData = outData;
            end
        end
        if (frameDone) doneCount++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic sel, input logic [15:0] bursts);
        bufSelect   = sel;
        frameBursts = bursts;
        frameStart  = 1'b1;
        @(negedge clk_100Mhz);
        frameStart  = 1'b0;
    endtask

    task automatic waitState(input string tag, input logic [1:0] st, input int budget);
        int n = 0;
        while (state !== st && n < budget) begin
            @(negedge clk_100Mhz);
            n++;
        end
        checkOutput(tag, 64'(state), 64'(st));
    endtask

    task automatic waitArvalid(input int budget);
        int n = 0;
        while (axi.ARVALID !== 1'b1 && n < budget) begin
            @(negedge clk_100Mhz);
            n++;
        end
        checkOutput("arvalidSeen", 64'(axi.ARVALID), 64'd1);
    endtask

    int ar0, wr0, bc0, rd0, l0, n;

    initial begin
        axi.ARREADY = 1'b1;
        repeat (3) @(negedge clk_100Mhz);
        checkOutput("rstState", 64'(state), 64'd0);
        checkOutput("rstArvalid", 64'(axi.ARVALID), 64'd0);
        checkOutput("rstRready", 64'(axi.RREADY), 64'd0);
        checkOutput("rstWrEn", 64'(outWrEn), 64'd0);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstAraddr", 64'(axi.ARADDR), 64'd0);
        checkOutput("rstErr", 64'(rrespErr), 64'd0);
        checkOutput("arlen", 64'(axi.ARLEN), 64'd3);
        checkOutput("arsize", 64'(axi.ARSIZE), 64'd2);
        checkOutput("arburst", 64'(axi.ARBURST), 64'd1);
        checkOutput("arcache", 64'(axi.ARCACHE), 64'd3);
        rst = 1'b0;
        @(negedge clk_100Mhz);
        checkOutput("rreadyRise", 64'(axi.RREADY), 64'd1);

        // Basic 20-burst frame from base0 with full credit
        applyStimulus(1'b0, 16'd20);
        checkOutput("basicRun", 64'(state), 64'd1);
        checkOutput("basicBusy", 64'(busy), 64'd1);
        checkOutput("basicNoArYet", 64'(axi.ARVALID), 64'd0);
        @(negedge clk_100Mhz);
        checkOutput("basicFirstAr", 64'(axi.ARVALID), 64'd1);
        checkOutput("basicFirstAddr", 64'(axi.ARADDR), 64'h1000_0000);
        waitState("basicDone", 2'd3, 500);
        repeat (2) @(negedge clk_100Mhz);
        checkOutput("basicArCount", 64'(arCount), 64'd20);
        checkOutput("basicAddr1", 64'(arLog[1]), 64'h1000_0010);
        checkOutput("basicAddr19", 64'(arLog[19]), 64'h1000_0130);
        checkOutput("basicWrites", 64'(wrCount), 64'd80);
        checkOutput("basicLastCnt", 64'(lastCount), 64'd1);
        checkOutput("basicDoneCnt", 64'(doneCount), 64'd1);
        checkOutput("basicLastData", 64'(lastData), 64'h1000_013C);
        checkOutput("basicBurstCnt", 64'(burstCnt), 64'd20);
        checkOutput("basicIdleBusy", 64'(busy), 64'd0);

        // Credit limit, then outstanding limit, with the slave withholding R
        ar0 = arCount; wr0 = wrCount; rd0 = rBurstsDone;
        rBurstLimit = rd0;
        outSpace = 11'd6;
        applyStimulus(1'b0, 16'd10);
        repeat (20) @(negedge clk_100Mhz);
        checkOutput("creditOneAr", 64'(arCount - ar0), 64'd1);
        checkOutput("creditBurstCnt", 64'(burstCnt), 64'd1);
        outSpace = 11'd8;
        repeat (10) @(negedge clk_100Mhz);
        checkOutput("creditSecondAr", 64'(arCount - ar0), 64'd2);
        outSpace = 11'd1024;
        repeat (20) @(negedge clk_100Mhz);
        checkOutput("outstStall", 64'(arCount - ar0), 64'd4);
        checkOutput("outstNoArvalid", 64'(axi.ARVALID), 64'd0);
        rBurstLimit = rd0 + 1;
        repeat (20) @(negedge clk_100Mhz);
        checkOutput("outstFifthAr", 64'(arCount - ar0), 64'd5);
        checkOutput("outstWrites", 64'(wrCount - wr0), 64'd4);

        // Abort with 3 bursts outstanding and a 6th AR stalled by ARREADY
        axi.ARREADY = 1'b0;
        rBurstLimit = rd0 + 2;
        repeat (20) @(negedge clk_100Mhz);
        checkOutput("abortArStalled", 64'(axi.ARVALID), 64'd1);
        checkOutput("abortArCount", 64'(arCount - ar0), 64'd5);
        wr0 = wrCount; bc0 = beatCount;
        applyStimulus(1'b1, 16'd3);
        checkOutput("abortDrain", 64'(state), 64'd2);
        repeat (10) @(negedge clk_100Mhz);
        checkOutput("abortArHeld", 64'(axi.ARVALID), 64'd1);
        checkOutput("abortAddrHeld", 64'(axi.ARADDR), 64'h1000_0050);
        axi.ARREADY = 1'b1;
        rBurstLimit = 1000000;
        waitState("abortRun", 2'd1, 200);
        checkOutput("abortNoWrites", 64'(wrCount - wr0), 64'd0);
        checkOutput("abortDrained", 64'(beatCount - bc0), 64'd16);
        checkOutput("abortArTotal", 64'(arCount - ar0), 64'd6);
        waitArvalid(20);
        checkOutput("abortNewBase", 64'(axi.ARADDR), 64'h2000_0000);
        waitState("abortDone", 2'd3, 200);
        repeat (2) @(negedge clk_100Mhz);
        checkOutput("abortWrites", 64'(wrCount - wr0), 64'd12);
        checkOutput("abortLastData", 64'(lastData), 64'h2000_002C);
        checkOutput("abortBurstCnt", 64'(burstCnt), 64'd3);

        // RRESP error on the 5th beat of a 2-burst frame
        wr0 = wrCount;
        errBeatNum = beatCount + 5;
        applyStimulus(1'b0, 16'd2);
        checkOutput("errClearBefore", 64'(rrespErr), 64'd0);
        waitState("errDone", 2'd3, 200);
        repeat (2) @(negedge clk_100Mhz);
        errBeatNum = -1;
        checkOutput("errSticky", 64'(rrespErr), 64'd1);
        checkOutput("errWrites", 64'(wrCount - wr0), 64'd8);
        checkOutput("errDataKept", 64'(wrLog[wr0 + 4]), 64'h1000_0010);

        // Empty frame: immediate DONE with frame_done, no out_last, no AR, error cleared
        ar0 = arCount;
        applyStimulus(1'b0, 16'd0);
        checkOutput("zeroState", 64'(state), 64'd3);
        checkOutput("zeroDonePulse", 64'(frameDone), 64'd1);
        checkOutput("zeroNoLast", 64'(outLast), 64'd0);
        checkOutput("zeroErrCleared", 64'(rrespErr), 64'd0);
        repeat (5) @(negedge clk_100Mhz);
        checkOutput("zeroNoAr", 64'(arCount - ar0), 64'd0);

        // frame_start coinciding with the final RLAST
        rd0 = rBurstsDone; l0 = lastCount;
        applyStimulus(1'b0, 16'd2);
        n = 0;
        while (!(axi.RVALID && axi.RLAST && rBurstsDone == rd0 + 1) && n < 200) begin
            @(negedge clk_100Mhz);
            n++;
        end
        bufSelect = 1'b1;
        frameBursts = 16'd1;
        frameStart = 1'b1;
        @(negedge clk_100Mhz);
        frameStart = 1'b0;
        checkOutput("coinLast", 64'(outLast), 64'd1);
        checkOutput("coinDone", 64'(frameDone), 64'd1);
        checkOutput("coinData", 64'(outData), 64'h1000_001C);
        checkOutput("coinRun", 64'(state), 64'd1);
        waitState("coinNextDone", 2'd3, 200);
        repeat (2) @(negedge clk_100Mhz);
        checkOutput("coinLastData", 64'(lastData), 64'h2000_000C);
        checkOutput("coinLastCnt", 64'(lastCount - l0), 64'd2);

        // Reset in the middle of a frame
        applyStimulus(1'b0, 16'd10);
        repeat (8) @(negedge clk_100Mhz);
        rst = 1'b1;
        @(negedge clk_100Mhz);
        checkOutput("midRstState", 64'(state), 64'd0);
        checkOutput("midRstArvalid", 64'(axi.ARVALID), 64'd0);
        checkOutput("midRstAraddr", 64'(axi.ARADDR), 64'd0);
        checkOutput("midRstRready", 64'(axi.RREADY), 64'd0);
        checkOutput("midRstWrEn", 64'(outWrEn), 64'd0);
        checkOutput("midRstBurstCnt", 64'(burstCnt), 64'd0);
        checkOutput("midRstBusy", 64'(busy), 64'd0);
        checkOutput("midRstData", 64'(outData), 64'd0);
        rst = 1'b0;
        @(negedge clk_100Mhz);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/axi4_frame_fetch.md
# axi4_frame_fetch

Parametrised AXI4 read master that fetches one video frame per `frame_start` from DDR (via the PS HP port) into a downstream single-clock write port, normally a dual-clock FIFO feeding the VTG/HDMI path. It is the successor of the single-burst frame reader. It adds:
- configurable data width and burst length;
- multiple outstanding bursts;
- credit-based flow control against downstream free space;
- double-buffer base selection latched per frame;
- clean mid-frame abort with R-beat drain;
- sticky RRESP error capture.

## Interface
Parameters:
- `AXI_ADDR_WIDTH`, default 32: AR address width.
- `AXI_DATA_WIDTH`, default 64: R data width. Must be a power of two, 8..1024.
- `BURST_LEN`, default 64: beats per burst. Power of two, 1..256. `BURST_LEN*AXI_DATA_WIDTH/8` must be ≤ 4096.
- `MAX_OUTST`, default 4: maximum accepted-but-incomplete bursts, 1..16.
- `SPACE_W`, default 11: width of `out_space`.

Ports:
- `clk_100Mhz` in 1: the only clock. Also drives AXI.
- `rst` in 1: synchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse that starts (or restarts) a frame. This is the vsync-derived pulse, already synchronised.
- `buf_select` in 1: chooses `base_addr1` (1) or `base_addr0` (0). Sampled on an accepted `frame_start`.
- `base_addr0`, `base_addr1` in `AXI_ADDR_WIDTH`: frame base addresses. Must be aligned to the burst byte size.
- `frame_bursts` in 16: bursts per frame. Sampled on an accepted `frame_start`.
- `out_space` in `SPACE_W`: free words downstream. Must never over-report, and must reflect an `out_wr_en` within 4 cycles.
- `out_wr_en` out 1, `out_data` out `AXI_DATA_WIDTH`, `out_last` out 1: registered write port. `out_last` marks the final beat of the frame.
- `frame_done` out 1: one-cycle pulse, coincident with `out_last`.
- `rresp_err` out 1: sticky flag, set on any accepted beat with `RRESP != 0`.
- `busy` out 1: high when state ≠ IDLE and ≠ DONE.
- `state` out 2: IDLE=0, RUN=1, DRAIN=2, DONE=3 (debug).
- `burst_cnt` out 16: bursts issued in the current frame (debug).
- `ARADDR` out `AXI_ADDR_WIDTH`, `ARVALID` out 1, `ARREADY` in 1.
- Constant AR fields:
  - `ARLEN` out 8 = `BURST_LEN-1`
  - `ARSIZE` out 3 = log2(`AXI_DATA_WIDTH/8`)
  - `ARBURST` out 2 = 01
  - `ARCACHE` out 4 = 0011
  - `ARPROT` out 3 = 000
- `RVALID` in 1, `RREADY` out 1, `RDATA` in `AXI_DATA_WIDTH`, `RRESP` in 2, `RLAST` in 1.

## Operation
Internal registers:
- `issued`: 16 bits.
- `reserved`: beats accepted on AR but not yet received. Width clog2(`MAX_OUTST*BURST_LEN`+1).
- `outst`: bursts outstanding.
- `rcv_bursts`: 16 bits.
- Latched `base` and `nbursts`.

State machine:
- **IDLE**
  - `frame_start` → latch `base`/`nbursts`, clear counters, clear `rresp_err`.
  - Go to RUN, or to DONE if `frame_bursts == 0` (with `frame_done` pulse, no `out_last`).
- **RUN**
  - Issue condition, all required, evaluated on registered values:
    - ARVALID = 0;
    - `issued < nbursts`;
    - `outst < MAX_OUTST`;
    - `out_space ≥ reserved + BURST_LEN`.
  - Issue: ARVALID ← 1 with ARADDR ← `base + issued*BURST_LEN*(AXI_DATA_WIDTH/8)`. Address arithmetic is modulo 2^`AXI_ADDR_WIDTH`.
  - AR handshake: ARVALID ← 0, `issued++`, `outst++`, `reserved += BURST_LEN`.
  - Next issue is possible no earlier than the cycle after the handshake.
  - Last beat of burst `nbursts-1` → DONE.
- **DONE**
  - Holds until `frame_start`, then acts as IDLE does.
- **Abort**
  - `frame_start` in RUN with `reserved == 0` and ARVALID = 0 → restart immediately, as from IDLE.
  - Otherwise → DRAIN. The new `buf_select`/`frame_bursts` are captured into pending registers.
- **DRAIN**
  - No new AR is issued.
  - A pending ARVALID stays high until ARREADY. AXI forbids withdrawal, so that burst is then drained.
  - Beats are accepted and discarded: `out_wr_en` stays 0.
  - A further `frame_start` overwrites the pending values.
  - When `reserved == 0` and ARVALID = 0 → start the pending frame in RUN.

R channel:
- RREADY = 1 in every state except during reset. Downstream space is guaranteed by the credit rule.
- Each beat (RVALID & RREADY):
  - `reserved--`;
  - `rresp_err` set if `RRESP != 0`. The data is still forwarded.
- On RLAST: `outst--`, `rcv_bursts++`.
- A simultaneous AR handshake and R beat gives `reserved += BURST_LEN-1`; `outst` nets the same way.

Output and coincidences:
- Forwarding (not DRAIN): `out_wr_en`/`out_data` are registered one cycle after the beat.
- `out_last` and `frame_done` are set on RLAST of burst `nbursts-1`.
- `frame_start` coinciding with that final beat: the beat is forwarded with `out_last`, and the new frame starts in RUN the next cycle (no DRAIN).
- `frame_start` while in DONE or IDLE is never dropped.

## Timing
- Reset values:
  - state IDLE;
  - ARVALID, RREADY, `out_wr_en`, `out_last`, `frame_done`, `rresp_err`, `busy` = 0;
  - ARADDR, `out_data`, `burst_cnt`, all counters = 0.
- RREADY rises the first cycle after `rst` deasserts.
- `rst` mid-burst abandons all AXI state. The interconnect must be reset together with this block.
- Latencies:
  - `frame_start` → first ARVALID: 2 cycles, if credit is available.
  - R beat → `out_wr_en`: 1 cycle.
- ARADDR and ARVALID are stable while ARVALID = 1 and ARREADY = 0.
- Peak issue rate: one AR every 2 cycles, limited by `MAX_OUTST` and credit.

## Test plan
- **Basic frame.** BURST_LEN=64, `frame_bursts=300`, base0=0x1000_0000, ARREADY always 1, zero-latency slave, `out_space` = 1024 → exactly 300 ARs at 0x1000_0000 + 512·n; 19200 `out_wr_en`; `out_last` and `frame_done` on beat 19200 only; DONE.
- **Credit limit.** `out_space` fixed at 100, nothing drained → exactly 1 AR issued and no second AR. Raise `out_space` to 128 → second AR issued.
- **Outstanding limit.** MAX_OUTST=4, slave withholds R → 4 ARs then stall. Release one burst → fifth AR.
- **Abort.** `frame_start` with 3 bursts outstanding and ARVALID stalled 10 cycles (`buf_select=1`) → ARVALID held until ARREADY; all 4·64 beats accepted with `out_wr_en` = 0; then RUN with first ARADDR = `base_addr1`.
- **Error.** RRESP=2'b10 on beat 5 → `rresp_err` = 1 from the next cycle, data still written; cleared on the next accepted `frame_start`.
- **Edges.**
  - `frame_bursts=0` → `frame_done` pulse, no AR.
  - `frame_start` on the final RLAST → `out_last` written, RUN next cycle.
  - `rst` mid-frame → every output returns to its reset value the next cycle.
